// File: rtl/operand_fetch_stage.sv
// ID/EX operand-fetch stage: drives regfile read addresses, bypasses same-cycle
// writebacks, registers operands plus pass-through fields, and refreshes them while stalled.
module operand_fetch_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 16,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rn,
  input  logic [REG_ADDR_W-1:0] in_rm,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic [REG_ADDR_W-1:0] readReg1,
  output logic [REG_ADDR_W-1:0] readReg2,
  input  logic [DATA_W-1:0]     readData1,
  input  logic [DATA_W-1:0]     readData2,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [REG_ADDR_W-1:0] out_rn,
  output logic [REG_ADDR_W-1:0] out_rm,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_imm,
  output logic [CTRL_W-1:0]     out_ctrl
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

  typedef struct packed {
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [REG_ADDR_W-1:0] rn;
    logic [REG_ADDR_W-1:0] rm;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     imm;
    logic [CTRL_W-1:0]     ctrl;
  } payload_t;

  payload_t payload_q, payload_d;
  logic     out_valid_q, out_valid_d;
  logic     accept, handoff, stalled;

  // A writeback to XZR never counts as a hit, so it can neither bypass nor refresh.
  function automatic logic wb_hit(input logic                  en,
                                  input logic [REG_ADDR_W-1:0] wreg,
                                  input logic [REG_ADDR_W-1:0] idx);
    return en && (wreg == idx) && (idx != ZERO_IDX);
  endfunction

  function automatic logic [DATA_W-1:0] select_operand(input logic [REG_ADDR_W-1:0] idx,
                                                       input logic [DATA_W-1:0]     rf_data,
                                                       input logic                  en,
                                                       input logic [REG_ADDR_W-1:0] wreg,
                                                       input logic [DATA_W-1:0]     wdata);
    if (idx == ZERO_IDX)       return '0;
    if (wb_hit(en, wreg, idx)) return wdata;
    return rf_data;
  endfunction

  assign readReg1 = in_rn;
  assign readReg2 = in_rm;

  assign in_ready = !out_valid_q || out_ready || flush;
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = out_valid_q && out_ready;
  assign stalled  = out_valid_q && !out_ready && !flush;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      payload_d.a  = select_operand(in_rn, readData1, wb_en, wb_reg, wb_data);
      payload_d.b  = select_operand(in_rm, readData2, wb_en, wb_reg, wb_data);
      payload_d.rn   = in_rn;
      payload_d.rm   = in_rm;
      payload_d.rd   = in_rd;
      payload_d.imm  = in_imm;
      payload_d.ctrl = in_ctrl;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end else if (stalled) begin
      if (wb_hit(wb_en, wb_reg, payload_q.rn)) payload_d.a = wb_data;
      if (wb_hit(wb_en, wb_reg, payload_q.rm)) payload_d.b = wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = payload_q.a;
  assign out_b     = payload_q.b;
  assign out_rn    = payload_q.rn;
  assign out_rm    = payload_q.rm;
  assign out_rd    = payload_q.rd;
  assign out_imm   = payload_q.imm;
  assign out_ctrl  = payload_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: a behavioural regfile supplies read data,
// and each handed-off payload must carry the current architectural value of its sources.
module tb_operand_fetch_stage;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_rn = '0, in_rm = '0, in_rd = '0;
  logic [DW-1:0] in_imm = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [AW-1:0] readReg1, readReg2;
  logic [DW-1:0] readData1, readData2;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_a, out_b, out_imm;
  logic [AW-1:0] out_rn, out_rm, out_rd;
  logic [CW-1:0] out_ctrl;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rn(out_rn), .out_rm(out_rm), .out_rd(out_rd), .out_imm(out_imm), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  // Regfile model; entry 31 holds junk on purpose, the stage must still read XZR as 0.
  logic [DW-1:0] rf [32];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 64'h1000 + DW'(i);
    end else if (wb_en) begin
      rf[wb_reg] <= wb_data;
    end
  end
  assign readData1 = rf[readReg1];
  assign readData2 = rf[readReg2];

  function automatic logic [DW-1:0] arch(input logic [AW-1:0] r);
    return (r == 5'd31) ? '0 : rf[r];
  endfunction

  typedef struct {
    logic [AW-1:0] rn, rm, rd;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } entry_t;

  entry_t sb[$];
  logic   mdl_ready = 1'b1;
  int     n_vec = 0;
  int     n_miss = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled at negedge, away from the capture edge.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      mdl_ready = 1'b1;
    end else begin
      mdl_ready = (sb.size() == 0) || out_ready || flush;
      check("in_ready", {63'd0, in_ready}, {63'd0, mdl_ready});
      check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (sb.size() != 0) begin
        if (flush) begin
          void'(sb.pop_front());
        end else if (out_ready) begin
          entry_t e;
          e = sb.pop_front();
          check("out_a", out_a, arch(e.rn));
          check("out_b", out_b, arch(e.rm));
          check("out_rn", {59'd0, out_rn}, {59'd0, e.rn});
          check("out_rm", {59'd0, out_rm}, {59'd0, e.rm});
          check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
          check("out_imm", out_imm, e.imm);
          check("out_ctrl", {48'd0, out_ctrl}, {48'd0, e.ctrl});
        end
      end
    end
  end

  // Advance one cycle; the expected entry is queued when the input is accepted.
  task automatic tick();
    @(posedge clk);
    if (reset && in_valid && mdl_ready && !flush)
      sb.push_back('{rn: in_rn, rm: in_rm, rd: in_rd, imm: in_imm, ctrl: in_ctrl});
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic wb_write(input logic [AW-1:0] r, input logic [DW-1:0] d);
    in_valid = 1'b0; wb_en = 1'b1; wb_reg = r; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_reg();
    int s = $urandom_range(0, 9);
    if (s < 6) return AW'($urandom_range(0, 3));
    if (s < 8) return 5'd31;
    return AW'($urandom_range(0, 31));
  endfunction

  initial begin
    // Reset held with an instruction presented.
    #1 reset = 1'b0;
    in_valid = 1'b1; in_rn = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_a", out_a, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    reset = 1'b1;
    in_valid = 1'b1; in_rn = 5'd2; out_ready = 1'b0;
    tick();
    check("first_accept_lat", {63'd0, out_valid}, 64'd1);
    idle();

    // Plain fetch.
    wb_write(5'd5, 64'h11);
    wb_write(5'd6, 64'h22);
    in_valid = 1'b1; in_rn = 5'd5; in_rm = 5'd6; out_ready = 1'b1;
    tick();
    check("fetch_a", out_a, 64'h11);
    check("fetch_b", out_b, 64'h22);
    idle();

    // Same-cycle bypass.
    in_valid = 1'b1; in_rn = 5'd5; in_rm = 5'd6;
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'hABC;
    tick();
    check("bypass_a", out_a, 64'hABC);
    idle();

    // XZR reads 0 even with a writeback to it.
    in_valid = 1'b1; in_rn = 5'd31; in_rm = 5'd31;
    wb_en = 1'b1; wb_reg = 5'd31; wb_data = -64'sd14;
    tick();
    check("xzr_a", out_a, 64'd0);
    check("xzr_b", out_b, 64'd0);
    idle();

    // Stall refresh then exactly one handoff.
    in_valid = 1'b1; in_rn = 5'd1; in_rm = 5'd7; out_ready = 1'b0;
    tick();
    out_ready = 1'b0;
    wb_write(5'd7, 64'h99);
    check("refresh_b", out_b, 64'h99);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    check("no_duplicate", {63'd0, out_valid}, 64'd0);
    idle();

    // Flush while stalled drops both held payload and the presented input.
    in_valid = 1'b1; in_rn = 5'd3; out_ready = 1'b0;
    tick();
    in_rn = 5'd4; flush = 1'b1;
    tick();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_not_captured", {63'd0, out_valid}, 64'd0);
    idle();

    // Back-to-back stream of four.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rd = AW'(i + 8); in_rn = pick_reg(); in_rm = pick_reg();
      in_imm = 64'(i); in_ctrl = CW'(i);
      tick();
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_rd", {59'd0, out_rd}, 64'(i + 8));
    end
    idle();

    // Reset mid-stall.
    in_valid = 1'b1; in_rn = 5'd3; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    #1 check("midstall_reset", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b1; in_rn = 5'd2; in_rm = 5'd3; out_ready = 1'b0;
    tick();
    check("post_reset_accept", {63'd0, out_valid}, 64'd1);
    idle();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rn     = pick_reg();
      in_rm     = pick_reg();
      in_rd     = AW'($urandom_range(0, 31));
      in_imm    = {$urandom(), $urandom()};
      in_ctrl   = CW'($urandom());
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_reg    = pick_reg();
      wb_data   = {$urandom(), $urandom()};
      flush     = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    repeat (3) idle();
    check("drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
